// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS multiply/divide unit:
// op codes, FSM state encoding and the default datapath width.
package mips_pkg;

  localparam int MD_WIDTH = 32;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_iter.sv
// One iteration of the mul/div datapath on a 2*W accumulator.
// Ports: mode (1=divide, only with MULDIV_DIV_EN), acc, opnd -> acc_nxt.
// mul: acc={partial,multiplier}; add opnd on lsb, shift right.
// div: acc={rem,dividend/quot}; shift left, restoring subtract.
module muldiv_iter #(
  parameter int W = 32
) (
`ifdef MULDIV_DIV_EN
  input  logic           mode,
`endif
  input  logic [2*W-1:0] acc,
  input  logic [W-1:0]   opnd,
  output logic [2*W-1:0] acc_nxt
);

  logic [W:0]     sum;
  logic [2*W-1:0] mul_nxt;

  always_comb begin
    sum = {1'b0, acc[2*W-1:W]};
    if (acc[0]) sum = sum + {1'b0, opnd};
    mul_nxt = {sum, acc[W-1:1]};
  end

`ifdef MULDIV_DIV_EN
  logic [W:0]     diff;
  logic [2*W-1:0] div_nxt;

  always_comb begin
    diff = acc[2*W-1:W-1] - {1'b0, opnd};
    if (!diff[W])
      div_nxt = {diff[W-1:0], acc[W-2:0], 1'b1};
    else
      div_nxt = {acc[2*W-2:0], 1'b0};
    acc_nxt = mode ? div_nxt : mul_nxt;
  end
`else
  always_comb acc_nxt = mul_nxt;
`endif

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU/MTHI/MTLO unit owning HI/LO.
// Ports: clk, rst (sync, high), start, op, a, b -> busy, done,
// hi, lo, div_by_zero. `define MULDIV_DIV_EN enables divide;
// without it DIV/DIVU act as reserved ops.
module muldiv_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int W2 = 2 * WIDTH;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [W2-1:0]    acc;
  logic [W2-1:0]    acc_nxt;
  logic [WIDTH-1:0] opnd;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic             pend;
  logic             pend_dbz;

  logic             accept;
  logic             dec_mul;
  logic             dec_div;
  logic             dec_mthi;
  logic             dec_mtlo;
  logic             b_zero;
  logic             sgn;
  logic             sa;
  logic             sb;
  logic             iter_go;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [W2-1:0]    prod;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;

  always_comb begin
    accept   = (state == ST_IDLE) && start;
    dec_mul  = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MULDIV_DIV_EN
    dec_div  = (op == OP_DIV) || (op == OP_DIVU);
`else
    dec_div  = 1'b0;
`endif
    dec_mthi = (op == OP_MTHI);
    dec_mtlo = (op == OP_MTLO);
    b_zero   = (b == '0);
    sgn      = (op == OP_MULT) || (op == OP_DIV);
    sa       = sgn & a[WIDTH-1];
    sb       = sgn & b[WIDTH-1];
    mag_a    = sa ? -a : a;
    mag_b    = sb ? -b : b;
    iter_go  = accept &&
               (dec_mul || (dec_div && !b_zero));
  end

  // Sign fix-up: products negate as one 2W value,
  // quotient and remainder negate independently.
  always_comb begin
    prod = neg_q ? -acc : acc;
    quo  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem  = neg_r ? -acc[W2-1:WIDTH] : acc[W2-1:WIDTH];
  end

  muldiv_iter #(
    .W       (WIDTH)
  ) u_iter (
`ifdef MULDIV_DIV_EN
    .mode    (is_div),
`endif
    .acc     (acc),
    .opnd    (opnd),
    .acc_nxt (acc_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (iter_go) state_nxt = ST_CALC;
      ST_CALC: if (cnt == '0) state_nxt = ST_FIX;
      ST_FIX:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      acc         <= '0;
      opnd        <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      pend        <= 1'b0;
      pend_dbz    <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done     <= 1'b0;
      pend     <= 1'b0;
      pend_dbz <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            if (!(dec_div && b_zero))
              div_by_zero <= 1'b0;
            unique case (1'b1)
              dec_mul: begin
                acc    <= {{WIDTH{1'b0}}, mag_b};
                opnd   <= mag_a;
                neg_q  <= sa ^ sb;
                neg_r  <= 1'b0;
                is_div <= 1'b0;
                cnt    <= CW'(WIDTH - 1);
              end
              dec_div: begin
                if (b_zero) begin
                  pend     <= 1'b1;
                  pend_dbz <= 1'b1;
                end else begin
                  acc    <= {{WIDTH{1'b0}}, mag_a};
                  opnd   <= mag_b;
                  neg_q  <= sa ^ sb;
                  neg_r  <= sa;
                  is_div <= 1'b1;
                  cnt    <= CW'(WIDTH - 1);
                end
              end
              dec_mthi: begin
                hi   <= a;
                pend <= 1'b1;
              end
              dec_mtlo: begin
                lo   <= a;
                pend <= 1'b1;
              end
              default: pend <= 1'b1;
            endcase
          end
        end
        ST_CALC: begin
          acc <= acc_nxt;
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        ST_FIX: begin
          if (is_div) begin
            hi <= rem;
            lo <= quo;
          end else begin
            hi <= prod[W2-1:WIDTH];
            lo <= prod[WIDTH-1:0];
          end
          done <= 1'b1;
        end
        default: ;
      endcase
      // Completion of a single-cycle op accepted last edge;
      // placed last so its flag survives a same-edge accept.
      if (pend) begin
        done <= 1'b1;
        if (pend_dbz) div_by_zero <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: random and directed ops
// checked against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        dbz;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (dbz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          k;
    int          lat;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          fails = 0;
  int          cyc = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic        m_dbz;

  always @(posedge clk) cyc++;

  task automatic chk(input string name,
                     input logic [63:0] got,
                     input logic [63:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%h want=%h @cyc %0d",
               name, got, want, cyc);
    end
  endtask

  // Reference: architectural result of each op.
  task automatic model(input logic [2:0] o,
                       input logic [31:0] x,
                       input logic [31:0] y,
                       input int k,
                       output int lat);
    exp_t        e;
    logic [63:0] p;
    longint      sx;
    longint      sy;
    lat   = 1;
    m_dbz = 1'b0;
    case (o)
      3'd0: begin
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        p  = 64'(sx * sy);
        {m_hi, m_lo} = p;
        lat = 33;
      end
      3'd1: begin
        p = {32'b0, x} * {32'b0, y};
        {m_hi, m_lo} = p;
        lat = 33;
      end
`ifdef MULDIV_DIV_EN
      3'd2, 3'd3: begin
        if (y == 32'd0) begin
          m_dbz = 1'b1;
        end else if (o == 3'd2) begin
          sx   = longint'($signed(x));
          sy   = longint'($signed(y));
          m_lo = 32'(sx / sy);
          m_hi = 32'(sx % sy);
          lat  = 33;
        end else begin
          m_lo = x / y;
          m_hi = x % y;
          lat  = 33;
        end
      end
`endif
      3'd4: m_hi = x;
      3'd5: m_lo = x;
      default: ;
    endcase
    e.hi  = m_hi;
    e.lo  = m_lo;
    e.dbz = m_dbz;
    e.k   = k;
    e.lat = lat;
    q.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after accept.
  task automatic issue(input logic [2:0] o,
                       input logic [31:0] x,
                       input logic [31:0] y);
    int lat;
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    model(o, x, y, cyc + 1, lat);
    @(negedge clk);
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    op    = 3'($urandom);
    chk("busy_after_accept", 64'(busy),
        64'(lat == 33));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL timeout waiting for done, %0d left",
               q.size());
      q.delete();
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && done) begin
        if (q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_done got=1 want=0 @cyc %0d",
                   cyc);
        end else begin
          e = q.pop_front();
          chk("hi", 64'(hi), 64'(e.hi));
          chk("lo", 64'(lo), 64'(e.lo));
          chk("div_by_zero", 64'(dbz), 64'(e.dbz));
          chk("latency", 64'(cyc - e.k), 64'(e.lat));
          chk("busy_at_done", 64'(busy), 64'd0);
        end
      end
    end
  end

  initial begin : driver
    logic [2:0]  o;
    logic [31:0] x;
    logic [31:0] y;
    rst   = 1'b1;
    start = 1'b0;
    op    = 3'd0;
    a     = 32'd0;
    b     = 32'd0;
    m_hi  = 32'd0;
    m_lo  = 32'd0;
    m_dbz = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_dbz", 64'(dbz), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle();
    issue(3'd0, -32'sd7, 32'd3);
    wait_idle();
    issue(3'd2, -32'sd7, 32'd2);
    wait_idle();
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle();
    issue(3'd3, 32'd10, 32'd0);
    wait_idle();
    issue(3'd1, 32'd3, 32'd4);
    wait_idle();
    issue(3'd4, 32'h1234, 32'd0);
    wait_idle();
    issue(3'd5, 32'h5678, 32'd0);
    wait_idle();
    issue(3'd6, 32'hDEAD, 32'hBEEF);
    wait_idle();
    issue(3'd7, 32'hDEAD, 32'hBEEF);
    wait_idle();

    // Second start while busy must be dropped.
    issue(3'd1, 32'd5, 32'd6);
    repeat (4) @(negedge clk);
    start = 1'b1;
    op    = 3'd4;
    a     = 32'd9;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);

    // Reset in the middle of an iterative op.
`ifdef MULDIV_DIV_EN
    issue(3'd3, 32'd100, 32'd7);
`else
    issue(3'd1, 32'd100, 32'd7);
`endif
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    q.delete();
    rst = 1'b0;
    m_hi  = 32'd0;
    m_lo  = 32'd0;
    m_dbz = 1'b0;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_hi", 64'(hi), 64'd0);
    chk("midrst_lo", 64'(lo), 64'd0);
    repeat (2) @(negedge clk);
    chk("midrst_nodone", 64'(done), 64'd0);
    issue(3'd1, 32'd2, 32'd3);
    wait_idle();

    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom_range(0, 7));
      x = $urandom;
      y = $urandom;
      if ($urandom_range(0, 7) == 0) y = 32'd0;
      if ($urandom_range(0, 9) == 0) begin
        x = 32'h8000_0000;
        y = 32'hFFFF_FFFF;
      end
      if ($urandom_range(0, 3) == 0) y = y >> 20;
      issue(o, x, y);
      wait_idle();
    end

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
